// File: rtl/pll_cfg_responder.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_responder
// Brief    : Avalon-MM fractional-PLL reconfig responder with shadow/commit
//            and a timed busy/lock sequence. Optional DPS: PLL_CFG_DPS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pll_cfg_responder #(
    parameter int          NUM_C        = 3,
    parameter int          RECFG_CYCLES = 16,
    parameter int          LOCK_CYCLES  = 64,
    parameter logic [17:0] M_INIT       = 18'h00606,
    parameter logic [17:0] N_INIT       = 18'h10000,
    parameter logic [17:0] C_INIT       = 18'h00505
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  cfg_write,
    input  logic                  cfg_read,
    input  logic [5:0]            cfg_address,
    input  logic [31:0]           cfg_writedata,
    output logic [31:0]           cfg_readdata,
    output logic                  cfg_waitrequest,
    output logic [17:0]           act_m,
    output logic [17:0]           act_n,
    output logic [18*NUM_C-1:0]   act_c,
    output logic [31:0]           act_mfrac,
    output logic [3:0]            act_bw,
    output logic [2:0]            act_cp,
    output logic [16*NUM_C-1:0]   c_phase,
    output logic                  busy,
    output logic                  pll_locked
);

    localparam logic [5:0]  c_num_c      = 6'(NUM_C);
    localparam logic [31:0] c_recfg_load = 32'(RECFG_CYCLES - 1);
    localparam logic [31:0] c_lock_load  = 32'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RECFG    = 2'd1,
`ifdef PLL_CFG_DPS_EN
        ST_LOCKWAIT = 2'd2,
        ST_SHIFT    = 2'd3
`else
        ST_LOCKWAIT = 2'd2
`endif
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_cnt;
    logic                   r_boot;
    logic                   r_busy;
    logic                   r_locked;
    logic                   r_mode;
    logic                   r_err;
    logic [31:0]            r_rdata;
    logic [4:0]             r_c_sel;

    logic [17:0]            r_sh_m, r_sh_n;
    logic [NUM_C-1:0][17:0] r_sh_c;
    logic [31:0]            r_sh_mfrac;
    logic [3:0]             r_sh_bw;
    logic [2:0]             r_sh_cp;

    logic [17:0]            r_act_m, r_act_n;
    logic [NUM_C-1:0][17:0] r_act_c;
    logic [31:0]            r_act_mfrac;
    logic [3:0]             r_act_bw;
    logic [2:0]             r_act_cp;

    logic                   w_wr_acc, w_rd_acc;
    logic                   w_wr_start, w_start_go, w_start_drop;
    logic                   w_c_ok, w_c_drop;
    logic                   w_dps_go, w_dps_drop;
    logic                   w_commit;
    logic [17:0]            w_c_rd;
    logic [31:0]            w_rmux;

    assign cfg_waitrequest = ~r_mode & r_busy;
    assign busy            = r_busy;
    assign pll_locked      = r_locked;
    assign cfg_readdata    = r_rdata;
    assign act_m           = r_act_m;
    assign act_n           = r_act_n;
    assign act_c           = r_act_c;
    assign act_mfrac       = r_act_mfrac;
    assign act_bw          = r_act_bw;
    assign act_cp          = r_act_cp;

    // A read coinciding with a write is dropped so readdata holds.
    assign w_wr_acc = cfg_write & ~cfg_waitrequest;
    assign w_rd_acc = cfg_read & ~cfg_write & ~cfg_waitrequest;

    assign w_wr_start   = w_wr_acc && (cfg_address == 6'd2);
    assign w_start_go   = w_wr_start && !r_boot &&
                          (r_state == ST_IDLE || r_state == ST_LOCKWAIT);
    assign w_start_drop = w_wr_start && !w_start_go;

    assign w_c_ok   = {1'b0, cfg_writedata[22:18]} < c_num_c;
    assign w_c_drop = w_wr_acc && (cfg_address == 6'd5) && !w_c_ok;
    assign w_commit = (r_state == ST_RECFG) && (r_cnt == 32'd0);

`ifdef PLL_CFG_DPS_EN
    logic                   w_wr_dps, w_dps_ok, w_dps_nz;
    logic [4:0]             r_dps_idx;
    logic                   r_dps_dir;
    logic [NUM_C-1:0][15:0] r_phase;

    assign w_wr_dps   = w_wr_acc && (cfg_address == 6'd6);
    assign w_dps_ok   = {1'b0, cfg_writedata[20:16]} < c_num_c;
    assign w_dps_nz   = cfg_writedata[15:0] != 16'd0;
    assign w_dps_go   = w_wr_dps && w_dps_ok && w_dps_nz &&
                        (r_state == ST_IDLE) && !r_boot;
    // Zero-count DPS with a valid index is a silent no-op.
    assign w_dps_drop = w_wr_dps && (!w_dps_ok || (w_dps_nz && !w_dps_go));
    assign c_phase    = r_phase;
`else
    assign w_dps_go   = 1'b0;
    assign w_dps_drop = 1'b0;
    assign c_phase    = '0;
`endif

    always_comb begin
        w_c_rd = 18'd0;
        for (int k = 0; k < NUM_C; k++) begin
            if (r_c_sel == k[4:0]) w_c_rd = r_sh_c[k];
        end
    end

    always_comb begin
        w_rmux = 32'd0;
        case (cfg_address)
            6'd0:    w_rmux = {31'd0, r_mode};
            6'd1:    w_rmux = {30'd0, r_err, ~r_busy};
            6'd3:    w_rmux = {14'd0, r_sh_n};
            6'd4:    w_rmux = {14'd0, r_sh_m};
            6'd5:    w_rmux = {9'd0, r_c_sel, w_c_rd};
            6'd7:    w_rmux = r_sh_mfrac;
            6'd8:    w_rmux = {28'd0, r_sh_bw};
            6'd9:    w_rmux = {29'd0, r_sh_cp};
            default: w_rmux = 32'd0;
        endcase
    end

    // Sequencer FSM: boot lock wait, reconfig/commit, lock wait, phase shift.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 32'd0;
            r_boot   <= 1'b1;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
`ifdef PLL_CFG_DPS_EN
            r_dps_idx <= 5'd0;
            r_dps_dir <= 1'b0;
            r_phase   <= '0;
`endif
        end else if (r_boot) begin
            r_boot  <= 1'b0;
            r_state <= ST_LOCKWAIT;
            r_cnt   <= c_lock_load;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_go) begin
                        r_state  <= ST_RECFG;
                        r_cnt    <= c_recfg_load;
                        r_busy   <= 1'b1;
                        r_locked <= 1'b0;
                    end
`ifdef PLL_CFG_DPS_EN
                    else if (w_dps_go) begin
                        r_state   <= ST_SHIFT;
                        r_cnt     <= {16'd0, cfg_writedata[15:0]};
                        r_busy    <= 1'b1;
                        r_dps_idx <= cfg_writedata[20:16];
                        r_dps_dir <= cfg_writedata[21];
                    end
`endif
                end
                ST_RECFG: begin
                    if (r_cnt == 32'd0) begin
                        r_state <= ST_LOCKWAIT;
                        r_cnt   <= c_lock_load;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                ST_LOCKWAIT: begin
                    if (w_start_go) begin
                        r_state <= ST_RECFG;
                        r_cnt   <= c_recfg_load;
                        r_busy  <= 1'b1;
                    end else if (r_cnt == 32'd0) begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
`ifdef PLL_CFG_DPS_EN
                ST_SHIFT: begin
                    for (int k = 0; k < NUM_C; k++) begin
                        if (r_dps_idx == k[4:0])
                            r_phase[k] <= r_dps_dir ? r_phase[k] + 16'd1
                                                    : r_phase[k] - 16'd1;
                    end
                    if (r_cnt == 32'd1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Register file: mode/err, shadows, atomic commit, registered read data.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'd0;
            r_c_sel     <= 5'd0;
            r_sh_m      <= M_INIT;
            r_sh_n      <= N_INIT;
            r_sh_c      <= {NUM_C{C_INIT}};
            r_sh_mfrac  <= 32'd0;
            r_sh_bw     <= 4'd0;
            r_sh_cp     <= 3'd0;
            r_act_m     <= M_INIT;
            r_act_n     <= N_INIT;
            r_act_c     <= {NUM_C{C_INIT}};
            r_act_mfrac <= 32'd0;
            r_act_bw    <= 4'd0;
            r_act_cp    <= 3'd0;
        end else begin
            if (w_wr_acc) begin
                case (cfg_address)
                    6'd0: begin
                        r_mode <= cfg_writedata[0];
                        r_err  <= 1'b0;
                    end
                    6'd3: r_sh_n <= cfg_writedata[17:0];
                    6'd4: r_sh_m <= cfg_writedata[17:0];
                    6'd5: begin
                        if (w_c_ok) begin
                            r_c_sel <= cfg_writedata[22:18];
                            for (int k = 0; k < NUM_C; k++) begin
                                if (cfg_writedata[22:18] == k[4:0])
                                    r_sh_c[k] <= cfg_writedata[17:0];
                            end
                        end
                    end
                    6'd7: r_sh_mfrac <= cfg_writedata;
                    6'd8: r_sh_bw    <= cfg_writedata[3:0];
                    6'd9: r_sh_cp    <= cfg_writedata[2:0];
                    default: ;
                endcase
            end
            if (w_c_drop || w_start_drop || w_dps_drop) r_err <= 1'b1;
            if (w_commit) begin
                r_act_m     <= r_sh_m;
                r_act_n     <= r_sh_n;
                r_act_c     <= r_sh_c;
                r_act_mfrac <= r_sh_mfrac;
                r_act_bw    <= r_sh_bw;
                r_act_cp    <= r_sh_cp;
            end
            if (w_rd_acc) r_rdata <= w_rmux;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_cfg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_cfg_responder
// Brief    : Directed, table-driven bench for pll_cfg_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_cfg_responder;

    localparam int          NUM_C = 3;
    localparam int          RC    = 16;
    localparam int          LC    = 64;
    localparam logic [17:0] MI    = 18'h00606;
    localparam logic [17:0] NI    = 18'h10000;
    localparam logic [17:0] CI    = 18'h00505;

    logic                  clk_sys = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  cfg_write = 1'b0;
    logic                  cfg_read = 1'b0;
    logic [5:0]            cfg_address = 6'd0;
    logic [31:0]           cfg_writedata = 32'd0;
    logic [31:0]           cfg_readdata;
    logic                  cfg_waitrequest;
    logic [17:0]           act_m, act_n;
    logic [18*NUM_C-1:0]   act_c;
    logic [31:0]           act_mfrac;
    logic [3:0]            act_bw;
    logic [2:0]            act_cp;
    logic [16*NUM_C-1:0]   c_phase;
    logic                  busy, pll_locked;

    pll_cfg_responder #(
        .NUM_C(NUM_C), .RECFG_CYCLES(RC), .LOCK_CYCLES(LC),
        .M_INIT(MI), .N_INIT(NI), .C_INIT(CI)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cfg_write(cfg_write), .cfg_read(cfg_read),
        .cfg_address(cfg_address), .cfg_writedata(cfg_writedata),
        .cfg_readdata(cfg_readdata), .cfg_waitrequest(cfg_waitrequest),
        .act_m(act_m), .act_n(act_n), .act_c(act_c), .act_mfrac(act_mfrac),
        .act_bw(act_bw), .act_cp(act_cp), .c_phase(c_phase),
        .busy(busy), .pll_locked(pll_locked)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic bus(input logic w, input logic r, input logic [5:0] a, input logic [31:0] d);
        cfg_write = w; cfg_read = r; cfg_address = a; cfg_writedata = d;
        cyc();
        cfg_write = 1'b0; cfg_read = 1'b0;
    endtask

    task automatic edges_to_lock(output int n);
        n = -1;
        for (int e = 1; e <= 300; e++) begin
            cyc();
            if (pll_locked) begin
                n = e;
                break;
            end
        end
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [5:0]  a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [21];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, commit_k, lock_k, wr_hi, busy_k;

        tbl[0]  = '{1'b0, 1'b1, 6'd4,  32'h0,        1'b1, 32'h00000606};
        tbl[1]  = '{1'b0, 1'b1, 6'd3,  32'h0,        1'b1, 32'h00010000};
        tbl[2]  = '{1'b0, 1'b1, 6'd0,  32'h0,        1'b1, 32'h00000000};
        tbl[3]  = '{1'b0, 1'b1, 6'd1,  32'h0,        1'b1, 32'h00000001};
        tbl[4]  = '{1'b0, 1'b1, 6'd12, 32'h0,        1'b1, 32'h00000000};
        tbl[5]  = '{1'b0, 1'b1, 6'd5,  32'h0,        1'b1, 32'h00000505};
        tbl[6]  = '{1'b1, 1'b0, 6'd4,  32'hFFF20504, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 6'd4,  32'h0,        1'b1, 32'h00020504};
        tbl[8]  = '{1'b1, 1'b0, 6'd3,  32'h00010000, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 6'd5,  32'h00080707, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 6'd5,  32'h0,        1'b1, 32'h00080707};
        tbl[11] = '{1'b1, 1'b0, 6'd7,  32'h12345678, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 6'd7,  32'h0,        1'b1, 32'h12345678};
        tbl[13] = '{1'b1, 1'b0, 6'd8,  32'hFFFFFFFA, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b1, 6'd8,  32'h0,        1'b1, 32'h0000000A};
        tbl[15] = '{1'b1, 1'b0, 6'd9,  32'h000000FD, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b1, 6'd9,  32'h0,        1'b1, 32'h00000005};
        tbl[17] = '{1'b1, 1'b1, 6'd9,  32'h00000003, 1'b1, 32'h00000005};
        tbl[18] = '{1'b0, 1'b1, 6'd9,  32'h0,        1'b1, 32'h00000003};
        tbl[19] = '{1'b1, 1'b0, 6'd10, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[20] = '{1'b0, 1'b1, 6'd10, 32'h0,        1'b1, 32'h00000000};

        // Reset state, then boot lock wait.
        #12;
        check("rst_readdata", cfg_readdata, 0);
        check("rst_busy_wait_lock", {busy, cfg_waitrequest, pll_locked}, 0);
        check("rst_act_mn", {act_m, act_n}, {MI, NI});
        check("rst_act_c", act_c, {CI, CI, CI});
        check("rst_act_misc", {act_mfrac, act_bw, act_cp}, 0);
        check("rst_phase", c_phase, 0);
        reset_n = 1'b1;
        edges_to_lock(n);
        check("boot_lock_edges", n, LC + 1);

        for (int i = 0; i < 21; i++) begin
            bus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
            if (tbl[i].chk) check($sformatf("vec%0d", i), cfg_readdata, tbl[i].exp);
        end
        check("shadow_not_active", {act_m, act_mfrac, act_bw, act_cp}, {MI, 32'h0, 4'h0, 3'h0});

        // Start, with a C write queued straight behind it (waitrequest mode).
        cfg_write = 1'b1; cfg_address = 6'd2; cfg_writedata = 32'h0;
        cyc();
        check("start_busy", {busy, cfg_waitrequest, pll_locked}, 3'b110);
        cfg_address = 6'd5; cfg_writedata = 32'h00040123;
        wr_hi = cfg_waitrequest ? 1 : 0;
        commit_k = -1; lock_k = -1;
        for (int k = 1; k <= RC + LC + 10; k++) begin
            cyc();
            if (cfg_waitrequest) wr_hi++;
            if (commit_k < 0 && act_m !== MI) commit_k = k;
            if (k == RC - 1) check("pre_commit", {act_c, act_bw}, {CI, CI, CI, 4'h0});
            if (k == RC) begin
                check("commit_mn", {act_m, act_n}, {18'h20504, 18'h10000});
                check("commit_c", act_c, {18'h00707, CI, CI});
                check("commit_misc", {act_mfrac, act_bw, act_cp}, {32'h12345678, 4'hA, 3'h3});
                check("commit_busy", busy, 0);
            end
            if (k == RC + 1) begin
                cfg_write = 1'b0; cfg_read = 1'b1; cfg_address = 6'd5;
            end
            if (k == RC + 2) begin
                cfg_read = 1'b0;
                check("stalled_c_landed", cfg_readdata, 32'h00040123);
                check("stalled_c_not_active", act_c, {18'h00707, CI, CI});
            end
            if (pll_locked) begin
                lock_k = k;
                break;
            end
        end
        cfg_write = 1'b0; cfg_read = 1'b0;
        check("wait_high_cycles", wr_hi, RC);
        check("commit_edge", commit_k, RC);
        check("lock_edge", lock_k, RC + LC);

        // Polling mode: status poll with a second start during RECFG.
        bus(1'b1, 1'b0, 6'd0, 32'h1);
        cfg_write = 1'b1; cfg_address = 6'd2;
        cyc();
        cfg_write = 1'b0; cfg_read = 1'b1; cfg_address = 6'd1;
        check("poll_no_wait", cfg_waitrequest, 0);
        busy_k = -1;
        for (int k = 1; k <= RC + 2; k++) begin
            cyc();
            if (k == 4) begin
                check("poll_busy", cfg_readdata, 0);
                cfg_write = 1'b1; cfg_address = 6'd2;
            end
            if (k == 5) begin
                check("rdwr_hold", cfg_readdata, 0);
                cfg_write = 1'b0; cfg_address = 6'd1;
            end
            if (k == 6) check("poll_err_busy", cfg_readdata, 32'h2);
            if (busy_k < 0 && !busy) busy_k = k;
            if (k == RC + 1) check("poll_done", cfg_readdata, 32'h3);
        end
        cfg_read = 1'b0;
        check("poll_busy_fall", busy_k, RC);

        // Bad C index during a restarted RECFG.
        bus(1'b1, 1'b0, 6'd0, 32'h1);
        bus(1'b0, 1'b1, 6'd1, 32'h0);
        check("status_clear", cfg_readdata, 32'h1);
        bus(1'b1, 1'b0, 6'd2, 32'h0);
        check("restart_lockwait", {busy, pll_locked}, 2'b10);
        bus(1'b1, 1'b0, 6'd5, 32'h0017FFFF);
        bus(1'b0, 1'b1, 6'd1, 32'h0);
        check("bad_idx_status", cfg_readdata, 32'h2);
        bus(1'b0, 1'b1, 6'd5, 32'h0);
        check("bad_idx_shadow", cfg_readdata, 32'h00040123);
        bus(1'b1, 1'b0, 6'd0, 32'h1);
        bus(1'b0, 1'b1, 6'd1, 32'h0);
        check("err_cleared", cfg_readdata, 32'h0);
        n = -1;
        for (int k = 0; k < 40; k++) begin
            if (!busy) begin
                n = k;
                break;
            end
            cyc();
        end
        check("recfg2_ends", n >= 0, 1);
        check("commit2_c", act_c, {18'h00707, 18'h00123, CI});
        edges_to_lock(n);
        check("relock", n > 0, 1);

`ifdef PLL_CFG_DPS_EN
        bus(1'b1, 1'b0, 6'd6, 32'h00010004);
        n = busy ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (busy) n++;
        end
        check("dps_busy_cycles", n, 4);
        check("dps_phase_neg", c_phase, {16'h0, 16'hFFFC, 16'h0});
        check("dps_locked", pll_locked, 1);
        bus(1'b1, 1'b0, 6'd6, 32'h00210000);
        check("dps_zero", {busy, c_phase}, {1'b0, 16'h0, 16'hFFFC, 16'h0});
        bus(1'b1, 1'b0, 6'd6, 32'h00200002);
        cyc();
        cyc();
        check("dps_phase_pos", c_phase, {16'h0, 16'hFFFC, 16'h0002});
`else
        bus(1'b1, 1'b0, 6'd6, 32'h00010004);
        check("dps_off_busy", busy, 0);
        bus(1'b0, 1'b1, 6'd1, 32'h0);
        check("dps_off_status", cfg_readdata, 32'h1);
        check("dps_off_phase", c_phase, 0);
`endif

        // Asynchronous reset in the middle of RECFG.
        bus(1'b1, 1'b0, 6'd2, 32'h0);
        for (int k = 0; k < 5; k++) cyc();
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_flags", {busy, cfg_waitrequest, pll_locked}, 0);
        check("mid_rst_readdata", cfg_readdata, 0);
        check("mid_rst_act", {act_m, act_n}, {MI, NI});
        check("mid_rst_act_c", act_c, {CI, CI, CI});
        check("mid_rst_misc", {act_mfrac, act_bw, act_cp}, 0);
        #2 reset_n = 1'b1;
        edges_to_lock(n);
        check("mid_rst_lock_edges", n, LC + 1);
        check("mid_rst_act_m", act_m, MI);
        bus(1'b0, 1'b1, 6'd0, 32'h0);
        check("mid_rst_mode", cfg_readdata, 0);
        bus(1'b0, 1'b1, 6'd4, 32'h0);
        check("mid_rst_shadow_m", cfg_readdata, {14'd0, MI});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_cfg_responder.md
# pll_cfg_responder

Avalon-MM responder for the fractional-PLL reconfiguration register map: it accepts the register writes issued by the core's PLL adjust sequencer, holds them in shadow registers, and commits them atomically when the start register is written. Between commit and lock it runs a timed busy/lock sequence. It serves as the bench and emulation stand-in for the vendor reconfig controller, and its `act_*` outputs drive the behavioural PLL model.

## Interface
- `NUM_C`, 3: number of C counters implemented (1–18).
- `RECFG_CYCLES`, 16: cycles from start acceptance to commit (≥2).
- `LOCK_CYCLES`, 64: cycles from commit to `pll_locked` rising (≥1).
- `M_INIT`, 18'h00606: reset value of shadow and active M.
- `N_INIT`, 18'h10000: reset value of shadow and active N.
- `C_INIT`, 18'h00505: reset value of every shadow and active C counter.
- `clk_sys`, in, 1: clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cfg_write`, in, 1: write request.
- `cfg_read`, in, 1: read request.
- `cfg_address`, in, 6: register address.
- `cfg_writedata`, in, 32: write data.
- `cfg_readdata`, out, 32: registered read data.
- `cfg_waitrequest`, out, 1: stall.
- `act_m`, out, 18: active M counter, laid out as {odd, bypass, hi[7:0], lo[7:0]}.
- `act_n`, out, 18: active N counter, same layout.
- `act_c`, out, 18*NUM_C: active C counters; counter k occupies bits [18k+17:18k].
- `act_mfrac`, out, 32: active fractional M.
- `act_bw`, out, 4: active bandwidth setting.
- `act_cp`, out, 3: active charge-pump setting.
- `c_phase`, out, 16*NUM_C: signed accumulated phase steps per C counter.
- `busy`, out, 1: reconfiguration or phase shift in progress.
- `pll_locked`, out, 1: lock indicator.

## Operation
- **Register map:**
  - 0: mode; bit0 = 0 selects waitrequest mode, 1 selects polling mode.
  - 1: status, read-only; returns {30'b0, err, ~busy}.
  - 2: start.
  - 3: N, bits [17:0].
  - 4: M, bits [17:0].
  - 5: C; bits [17:0] are the counter value, bits [22:18] the counter index.
  - 6: DPS; bits [15:0] are the step count, [20:16] the counter index, [21] the direction (1 = positive).
  - 7: MFRAC.
  - 8: bandwidth, bits [3:0].
  - 9: charge pump, bits [2:0].
  - Other addresses: writes are ignored, reads return 0.
- **Shadow commit:** writes to addresses 3–5 and 7–9 update shadow registers only. The `act_*` outputs change only at commit, and all of them change in the same edge.
- **C index range:** a C write or DPS write whose index is ≥ NUM_C is dropped and sets `err`. `err` is sticky and is cleared by a write to the mode register.
- **FSM states:** IDLE, RECFG, LOCKWAIT, SHIFT.
  - IDLE to RECFG: start write accepted (any data value). `pll_locked` drops to 0 and the counter loads RECFG_CYCLES−1.
  - RECFG to LOCKWAIT: counter reaches 0. This is the commit edge; the counter loads LOCK_CYCLES−1.
  - LOCKWAIT to IDLE: counter reaches 0; `pll_locked` goes to 1.
  - IDLE to SHIFT: DPS write with step count ≠0. `c_phase[idx]` changes by ±1 per cycle for `count` cycles, then the FSM returns to IDLE.
  - A DPS write with step count 0 is accepted with no effect.
- **`busy`:** equals 1 when the state is RECFG or SHIFT. `pll_locked` is unaffected by SHIFT.
- **Waitrequest mode:**
  - `cfg_waitrequest` = `busy`; requests are stalled until `busy` clears.
  - `cfg_waitrequest` is 0 in IDLE and in LOCKWAIT.
- **Polling mode:**
  - `cfg_waitrequest` is constantly 0.
  - Shadow writes during `busy` are accepted.
  - Start or DPS writes during `busy` are dropped and set `err`.
  - A start write during LOCKWAIT restarts RECFG.
- **Simultaneous requests:** when `cfg_read` and `cfg_write` are both high, the write is serviced and the read is ignored; `cfg_readdata` holds its value.
- **Reset:** asynchronous reset clears everything, including mid-RECFG or mid-SHIFT.
  - Reset values: shadow and active registers from the parameters, mode 0, MFRAC/BW/CP 0, `c_phase` 0, `err` 0, state IDLE, `cfg_readdata` 0, `cfg_waitrequest` 0, `busy` 0, `pll_locked` 0.
  - After reset release the FSM enters LOCKWAIT at the first edge, so `pll_locked` rises LOCK_CYCLES edges later.

## Timing
- **Acceptance:** a request is accepted at edge T when it is asserted and `cfg_waitrequest` = 0.
- **Shadow writes:** the shadow register is updated at T and is readable from T+1.
- **Read latency:** fixed at 1. `cfg_readdata` is valid after edge T and holds until the next accepted read.
- **Start:** for a start accepted at T, `busy` = 1 and `pll_locked` = 0 after T.
  - Commit and `busy` falling occur at T+RECFG_CYCLES.
  - `pll_locked` rises at T+RECFG_CYCLES+LOCK_CYCLES.
- **DPS:** for a DPS write accepted at T with count n, `busy` is high for n cycles. The final `c_phase` value is visible after T+n. Phase arithmetic wraps modulo 2^16.

## Configuration
- **`PLL_CFG_DPS_EN` defined:** address 6 and the SHIFT state are implemented as described.
- **`PLL_CFG_DPS_EN` undefined:**
  - Writes to address 6 are accepted and ignored; they cause no `busy` and no `err`.
  - `c_phase` is tied to 0.
  - The SHIFT state is absent.

## Test plan
- **Shadow/commit:**
  - Stimulus: write M=18'h20504, N=18'h10000, C index 2 = 18'h00707, then write start.
  - Required: `act_*` outputs stay unchanged until exactly RECFG_CYCLES edges after the start, then all update in one edge.
  - Required: `pll_locked` rises LOCK_CYCLES edges after the commit.
- **Waitrequest mode:** issue a C write immediately after a start. `cfg_waitrequest` stays high for RECFG_CYCLES cycles, and the write lands one edge after it drops.
- **Polling mode:**
  - Stimulus: set mode=1, then poll address 1 after a start.
  - Required: reads return 0 while `busy` and 1 afterwards.
  - Stimulus: issue a second start during RECFG.
  - Required: `err`=1 and timing unchanged.
- **Bad index:** a C write with index 5 (NUM_C=3) leaves all shadows unchanged and the status read returns 32'h2. A subsequent mode write clears `err`.
- **DPS** (`PLL_CFG_DPS_EN` defined): write count=4, index 1, negative direction. `busy` is high for 4 cycles and `c_phase[1]` = 16'hFFFC.
- **Reset mid-RECFG:**
  - Stimulus: assert `reset_n`=0 at RECFG cycle 5.
  - Required: outputs take their reset values immediately.
  - Required: after release, `pll_locked` rises after LOCK_CYCLES edges with `act_m`=M_INIT.
